seg7_scan_scheduler: RTL and testbench

- Time-multiplexes the four-digit, common-anode seven-segment display between four digit sources.
- Each digit gets a fixed refresh slot. Decodes that digit's nibble to hex segments, drives the decimal point and applies leading-zero suppression.
- Sits between the switch/counter datapath (which presents a 16-bit value) and the board pins seg/an/dp.
- Double-buffers the displayed value so updates only take effect at frame boundaries, which prevents tearing.

---
 rtl/seg7_scan_if.sv | 18 +
 rtl/seg7_scan_scheduler.sv | 109 ++++++++++
 tb/tb_seg7_scan_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-side bundle between the datapath and the seven-segment scan scheduler.
// The datapath drives value/strobes; the scheduler drives the board pins and pending flag.
interface seg7_scan_if;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  modport master (output en, value, load, dp_en, blank_lz,
                  input  pending, seg, dp, an);
  modport slave  (input  en, value, load, dp_en, blank_lz,
                  output pending, seg, dp, an);
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Four-digit common-anode 7-seg scanner: guarded digit slots, hex decode,
// leading-zero blanking, and a pending/shadow pair committed at frame end.
module seg7_scan_scheduler #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);
  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GRD = CW'(GUARD);

  typedef enum logic {GUARD_OFF, DRIVE} phase_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d, pend_q, pend_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  phase_e        phase;
  logic          wrap, frame_end;
  logic [3:0]    nib, supp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap      = bus.en && (cnt_q == CNT_MAX);
    frame_end = wrap && (idx_q == 2'd3);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (bus.en) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    if (wrap)   idx_d = idx_q + 2'd1;

    // A load coinciding with the frame end bypasses pend and lands in shadow.
    pend_d    = pend_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (bus.load) pend_d = bus.value;
    if (frame_end) begin
      pending_d = 1'b0;
      if (bus.load)       shadow_d = bus.value;
      else if (pending_q) shadow_d = pend_q;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    supp[0] = 1'b0;
    supp[1] = bus.blank_lz && (shadow_q[15:4]  == 12'h000);
    supp[2] = bus.blank_lz && (shadow_q[15:8]  == 8'h00);
    supp[3] = bus.blank_lz && (shadow_q[15:12] == 4'h0);

    phase = (cnt_q < CNT_GRD) ? GUARD_OFF : DRIVE;
    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (phase == DRIVE && bus.en && !supp[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~bus.dp_en[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      pend_q    <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler (REFRESH_DIV=8, GUARD=2): a cycle-indexed
// table of expected pin/pending values, with load/en/rst actions scripted per cycle.
module tb_seg7_scan_scheduler;
  logic clk;
  logic rst;
  seg7_scan_if bus ();

  seg7_scan_scheduler #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(int t, logic [3:0] an, logic [6:0] seg, logic dp, logic p);
    vec_t v;
    v.t = t; v.an = an; v.seg = seg; v.dp = dp; v.pend = p;
    return v;
  endfunction

  function automatic vec_t blk(int t, logic p);
    return mk(t, 4'b1111, 7'b1111111, 1'b1, p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int t, vec_t v);
    nvec++;
    if (bus.an !== v.an || bus.seg !== v.seg || bus.dp !== v.dp || bus.pending !== v.pend) begin
      nerr++;
      $display("FAIL %s t=%0d got an=%b seg=%b dp=%b pend=%b want an=%b seg=%b dp=%b pend=%b",
               name, t, bus.an, bus.seg, bus.dp, bus.pending, v.an, v.seg, v.dp, v.pend);
    end
  endtask

  task automatic check_onehot(int t);
    nvec++;
    if ($countones(~bus.an) > 1) begin
      nerr++;
      $display("FAIL anode_overlap t=%0d got an=%b want at most one low", t, bus.an);
    end
  endtask

  initial begin
    int vi;
    // t = cycles since reset release; pins at t reflect counter state at t-1.
    vecs.push_back(blk(1, 1'b1));
    vecs.push_back(mk(3,   4'b1110, 7'b1000000, 1'b1, 1'b1));
    vecs.push_back(mk(31,  4'b0111, 7'b1000000, 1'b1, 1'b1));
    vecs.push_back(mk(32,  4'b0111, 7'b1000000, 1'b1, 1'b0));
    vecs.push_back(blk(33, 1'b0));
    vecs.push_back(blk(34, 1'b0));
    vecs.push_back(mk(35,  4'b1110, 7'b0011001, 1'b1, 1'b0));
    vecs.push_back(mk(40,  4'b1110, 7'b0011001, 1'b1, 1'b0));
    vecs.push_back(blk(41, 1'b0));
    vecs.push_back(blk(42, 1'b0));
    vecs.push_back(mk(43,  4'b1101, 7'b0110000, 1'b1, 1'b0));
    vecs.push_back(mk(45,  4'b1101, 7'b0110000, 1'b1, 1'b1));
    vecs.push_back(mk(51,  4'b1011, 7'b0100100, 1'b1, 1'b1));
    vecs.push_back(mk(59,  4'b0111, 7'b1111001, 1'b1, 1'b1));
    vecs.push_back(mk(63,  4'b0111, 7'b1111001, 1'b1, 1'b1));
    vecs.push_back(mk(64,  4'b0111, 7'b1111001, 1'b1, 1'b0));
    vecs.push_back(blk(65, 1'b0));
    vecs.push_back(mk(67,  4'b1110, 7'b0100001, 1'b1, 1'b0));
    vecs.push_back(mk(75,  4'b1101, 7'b1000110, 1'b1, 1'b0));
    vecs.push_back(blk(81, 1'b1));
    vecs.push_back(mk(83,  4'b1011, 7'b0000011, 1'b1, 1'b1));
    vecs.push_back(mk(91,  4'b0111, 7'b0001000, 1'b1, 1'b1));
    vecs.push_back(mk(95,  4'b0111, 7'b0001000, 1'b1, 1'b1));
    vecs.push_back(mk(96,  4'b0111, 7'b0001000, 1'b1, 1'b0));
    vecs.push_back(mk(99,  4'b1110, 7'b1000000, 1'b1, 1'b0));
    vecs.push_back(mk(107, 4'b1101, 7'b0001110, 1'b1, 1'b1));
    vecs.push_back(mk(115, 4'b1011, 7'b1000000, 1'b1, 1'b1));
    vecs.push_back(mk(123, 4'b0111, 7'b1000000, 1'b1, 1'b1));
    vecs.push_back(mk(131, 4'b1110, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(mk(139, 4'b1101, 7'b1111000, 1'b0, 1'b0));
    vecs.push_back(mk(141, 4'b1101, 7'b1111000, 1'b0, 1'b1));
    vecs.push_back(blk(147, 1'b1));
    vecs.push_back(blk(155, 1'b1));
    vecs.push_back(mk(163, 4'b1110, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(blk(171, 1'b0));
    vecs.push_back(blk(179, 1'b0));
    vecs.push_back(blk(187, 1'b0));
    vecs.push_back(mk(195, 4'b1110, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(mk(203, 4'b1101, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(blk(210, 1'b0));
    vecs.push_back(blk(212, 1'b0));
    vecs.push_back(blk(216, 1'b1));
    vecs.push_back(blk(230, 1'b1));
    vecs.push_back(mk(231, 4'b1011, 7'b1000000, 1'b0, 1'b1));
    vecs.push_back(mk(236, 4'b1011, 7'b1000000, 1'b0, 1'b1));
    vecs.push_back(blk(237, 1'b1));
    vecs.push_back(mk(239, 4'b0111, 7'b1000000, 1'b0, 1'b1));
    vecs.push_back(mk(243, 4'b0111, 7'b1000000, 1'b0, 1'b1));
    vecs.push_back(mk(244, 4'b0111, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(mk(247, 4'b1110, 7'b1111001, 1'b0, 1'b0));
    vecs.push_back(mk(251, 4'b1110, 7'b1111001, 1'b0, 1'b1));
    vecs.push_back(blk(256, 1'b0));
    vecs.push_back(blk(257, 1'b0));
    vecs.push_back(mk(259, 4'b1110, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(mk(283, 4'b0111, 7'b1000000, 1'b0, 1'b0));
    vecs.push_back(blk(290, 1'b0));

    rst = 1'b1;
    bus.en = 1'b0; bus.value = 16'h0000; bus.load = 1'b0;
    bus.dp_en = 4'b0000; bus.blank_lz = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step();
      check("reset", -r, blk(0, 1'b0));
    end

    rst = 1'b0; bus.en = 1'b1; bus.load = 1'b1; bus.value = 16'h1234;
    vi = 0;
    for (int t = 1; t <= 300; t++) begin
      step();
      check_onehot(t);
      while (vi < vecs.size() && vecs[vi].t == t) begin
        check("vec", t, vecs[vi]);
        vi++;
      end
      bus.load = 1'b0;
      case (t)
        44:  begin bus.load = 1'b1; bus.value = 16'hABCD; end
        80:  begin bus.load = 1'b1; bus.value = 16'h5555; end
        95:  begin bus.load = 1'b1; bus.value = 16'h00F0; end
        100: begin bus.load = 1'b1; bus.value = 16'h0070; end
        127: begin bus.blank_lz = 1'b1; bus.dp_en = 4'b1111; end
        140: begin bus.load = 1'b1; bus.value = 16'h0000; end
        192: bus.blank_lz = 1'b0;
        210: bus.en = 1'b0;
        215: begin bus.load = 1'b1; bus.value = 16'h0001; end
        230: bus.en = 1'b1;
        250: begin bus.load = 1'b1; bus.value = 16'h2222; end
        255: rst = 1'b1;
        256: rst = 1'b0;
        default: ;
      endcase
    end

    nvec++;
    if (vi != vecs.size()) begin
      nerr++;
      $display("FAIL table_coverage got %0d vectors reached want %0d", vi, vecs.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
